// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: CON condition encodings, FSM states and a
// saturating counter helper used by the optional BRANCH_STATS_EN statistics.
package branch_resolve_unit_pkg;

  localparam logic [1:0] COND_ZR = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_PL = 2'b10;
  localparam logic [1:0] COND_MI = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RA,
    EVAL,
    UPDATE
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational CON evaluator: decides whether a branch is taken from Ra and the C2 field.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned BITS = 32
) (
  input  logic [BITS-1:0] ra_i,
  input  logic [1:0]      cond_i,
  output logic            taken_o
);

  // Zero counts as positive, so COND_PL only looks at the sign bit.
  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      COND_ZR: taken_o = (ra_i == '0);
      COND_NZ: taken_o = (ra_i != '0);
      COND_PL: taken_o = ~ra_i[BITS-1];
      COND_MI: taken_o = ra_i[BITS-1];
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Conditional branch resolver: latches the request, waits for Ra on the bus, evaluates CON
// and issues a one-cycle PC load. Define BRANCH_STATS_EN to add taken/not-taken counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned BITS     = 32,
  parameter int unsigned OFF_BITS = 19
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [1:0]          ir_c2,
  input  logic [OFF_BITS-1:0] offset,
  input  logic [BITS-1:0]     pc_in,
  input  logic                ra_valid,
  input  logic [BITS-1:0]     bus,
  output logic                busy,
  output logic                con_q,
  output logic [BITS-1:0]     pc_out,
  output logic                pc_load,
`ifdef BRANCH_STATS_EN
  output logic [15:0]         taken_cnt,
  output logic [15:0]         not_taken_cnt,
`endif
  output logic                done
);

  state_e          state_q, state_d;
  logic [1:0]      cond_q;
  logic [BITS-1:0] off_q;
  logic [BITS-1:0] pc_q;
  logic [BITS-1:0] ra_q;
  logic [BITS-1:0] target;
  logic            taken;

  branch_cond_eval #(
    .BITS (BITS)
  ) u_cond_eval (
    .ra_i    (ra_q),
    .cond_i  (cond_q),
    .taken_o (taken)
  );

  assign target = pc_q + off_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = WAIT_RA;
      WAIT_RA: if (ra_valid) state_d = EVAL;
      EVAL:    state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == UPDATE);
    pc_load = (state_q == UPDATE) && con_q;
  end

  // pc_out is resolved on the EVAL edge so it is already valid while pc_load is high.
  always_ff @(posedge clk) begin
    if (!clr) begin
      cond_q <= '0;
      off_q  <= '0;
      pc_q   <= '0;
      ra_q   <= '0;
      con_q  <= 1'b0;
      pc_out <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        cond_q <= ir_c2;
        off_q  <= {{(BITS - OFF_BITS){offset[OFF_BITS-1]}}, offset};
        pc_q   <= pc_in;
      end
      if (state_q == WAIT_RA && ra_valid) begin
        ra_q <= bus;
      end
      if (state_q == EVAL) begin
        con_q  <= taken;
        pc_out <= taken ? target : pc_q;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!clr) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else if (state_q == UPDATE) begin
      if (con_q) begin
        taken_cnt <= sat_inc16(taken_cnt);
      end else begin
        not_taken_cnt <= sat_inc16(not_taken_cnt);
      end
    end
  end
`else
  // Without BRANCH_STATS_EN there are no statistics counters.
`endif

endmodule
